collision_event_scheduler: RTL
==============================

Name: collision_event_scheduler

Overview:
- Sits between the per-pixel collision detector and the game controller.
- Accumulates single-pixel collision pulses over a video frame, snapshots them at start of frame, and serializes them as one event at a time over a valid/ready handshake.
- Dispatch follows fixed priority.
- Masks fruit events after they are reported once, until the next level clear.

Parameters:
- NUM_SRC, 15, number of collision sources (width of coll_vec).
- ID_W, 4, width of event_id; must satisfy 2**ID_W >= NUM_SRC.
- ONCE_MASK, 15'h7FE0, bits reported only once until clear_mask (the fruit bits).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at the start of each frame.
- enable  in  1  accumulate collisions when 1 (game running); when 0, coll_vec is ignored.
- coll_vec  in  NUM_SRC  per-pixel collision flags, mapped as:
  - bit0 monster, bit1 key, bit2 boarders, bit3 ground, bit4 rope, bits5..14 fruit1..fruit10.
- clear_mask  in  1  one-cycle pulse (level restart) that clears the once-mask.
- event_ready  in  1  consumer accepts the presented event.
- event_valid  out  1  an event is presented.
- event_id  out  ID_W  index of the presented event.
- pending_cnt  out  ID_W+1  number of pending undispatched events.
- overrun  out  1  one-cycle pulse when a snapshot arrives while events are still pending.
- once_mask_o  out  NUM_SRC  current once-mask (debug/score logic).

Behaviour:
- Reset (resetN=0, async): accum, pending and once_mask are 0; state IDLE; event_valid=0, event_id=0, overrun=0, pending_cnt=0. Reset mid-handshake drops the presented event silently.
- Accumulation: each cycle with enable=1 and startOfFrame=0: accum <= accum | (coll_vec & ~(once_mask & ONCE_MASK)).
- Snapshot, on the startOfFrame cycle:
  - snap = accum | (enable ? coll_vec & ~(once_mask & ONCE_MASK) : 0).
  - accum <= 0.
  - pending <= (pending & ~acc_bit) | snap, where acc_bit is the one-hot of event_id if event_valid & event_ready in that cycle, else 0.
  - overrun = 1 for one cycle if (pending & ~acc_bit) != 0 and snap != 0.
- Priority: lowest set index in pending wins (monster first, fruit10 last).
- FSM, all outputs registered:
  - IDLE: if pending != 0, go to LOAD.
  - LOAD: event_id <= priority-encode(pending); event_valid <= 1; go to PRESENT.
  - PRESENT:
    - event_valid and event_id stay stable until event_ready=1.
    - On acceptance: clear pending[event_id]; if ONCE_MASK[event_id], set once_mask[event_id]; event_valid <= 0 next cycle.
    - Next state is LOAD if the remaining pending != 0, else IDLE.
  - Throughput: at most one event per 2 cycles; the first event is valid 2 cycles after the snapshot edge.
  - A higher-priority bit arriving through a snapshot does not preempt the presented event; it is chosen at the next LOAD.
- clear_mask: once_mask <= 0. If it coincides with a fruit acceptance, clear wins (the bit stays 0).
- pending_cnt: popcount of pending, registered, updated the cycle after pending changes.
- Duplicates: a source is at most one pending bit; repeated hits in a frame collapse into one event. An unmasked source may re-report every frame.
- enable=0: accumulation stops; snapshot and dispatch of already-pending events continue.

Test Plan:
- Reset, frame 1, ground only:
  - Stimulus: coll_vec=15'h0008 for 3 cycles mid-frame, then a startOfFrame pulse.
  - Required: event_valid rises 2 cycles later with event_id=3; ready held 1 -> one event, then IDLE, pending_cnt 1->0.
- Priority:
  - Stimulus: bits 0, 4 and 7 hit in one frame; ready always 1.
  - Required: event_id sequence 0, 4, 7 at 2-cycle spacing; no further events.
- Once-mask:
  - Stimulus: fruit1 (bit5) hits in two consecutive frames.
  - Required: reported only in the first frame; once_mask_o=15'h0020.
  - Continue: clear_mask pulse, then fruit1 hits again -> reported again.
- Backpressure/overrun:
  - Stimulus: ready=0; bits 1 and 2 pending; next startOfFrame carries bit 3.
  - Required: overrun pulses one cycle; event_id stays 1 stable; after release, order is 1, 2, 3.
- Simultaneous accept and snapshot:
  - Stimulus: event_id=2 accepted on the startOfFrame cycle, with bit2 in the new snap.
  - Required: bit2 is re-reported after the others; pending_cnt is correct.
- Async reset mid-PRESENT:
  - Stimulus: resetN low for 1 cycle while event_valid=1.
  - Required: all outputs 0 immediately; no event after release until a new snapshot.

Source files
------------

// File: rtl/collision_event_scheduler_if.sv
// Event handshake between the collision scheduler (master) and the game controller (slave).
interface collision_event_scheduler_if #(
  parameter int unsigned ID_W = 4
) ();
  logic            event_valid;
  logic            event_ready;
  logic [ID_W-1:0] event_id;

  modport master (
    output event_valid,
    output event_id,
    input  event_ready
  );

  modport slave (
    input  event_valid,
    input  event_id,
    output event_ready
  );
endinterface

// File: rtl/collision_event_scheduler.sv
// Collision event scheduler: accumulates per-pixel collision pulses over a frame, snapshots
// them at start of frame and dispatches one event at a time, lowest index first. Fruit
// sources are reported once until the next level clear.
module collision_event_scheduler #(
  parameter int unsigned          NUM_SRC   = 15,
  parameter int unsigned          ID_W      = 4,
  parameter logic [NUM_SRC-1:0]   ONCE_MASK = 15'h7FE0
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    startOfFrame,
  input  logic                    enable,
  input  logic [NUM_SRC-1:0]      coll_vec,
  input  logic                    clear_mask,
  collision_event_scheduler_if.master evt,
  output logic [ID_W:0]           pending_cnt,
  output logic                    overrun,
  output logic [NUM_SRC-1:0]      once_mask_o
);

  typedef enum logic [1:0] {StIdle, StLoad, StPresent} state_e;

  state_e              state_q, state_d;
  logic [NUM_SRC-1:0]  accum_q, accum_d;
  logic [NUM_SRC-1:0]  pending_q, pending_d;
  logic [NUM_SRC-1:0]  once_mask_q, once_mask_d;
  logic                event_valid_q, event_valid_d;
  logic [ID_W-1:0]     event_id_q, event_id_d;
  logic                overrun_q, overrun_d;
  logic [ID_W:0]       pending_cnt_q, pending_cnt_d;

  logic                accept;
  logic [NUM_SRC-1:0]  acc_bit;
  logic [NUM_SRC-1:0]  masked_coll;
  logic [NUM_SRC-1:0]  snap;
  logic [NUM_SRC-1:0]  pending_left;
  logic [ID_W-1:0]     prio_id;

  // Datapath: accumulation, snapshot, pending bookkeeping, once-mask and popcount.
  always_comb begin
    accept       = event_valid_q & evt.event_ready;
    acc_bit      = accept ? (NUM_SRC'(1) << event_id_q) : '0;
    masked_coll  = enable ? (coll_vec & ~(once_mask_q & ONCE_MASK)) : '0;
    snap         = accum_q | masked_coll;
    pending_left = pending_q & ~acc_bit;

    accum_d   = startOfFrame ? '0 : (accum_q | masked_coll);
    pending_d = startOfFrame ? (pending_left | snap) : pending_left;
    overrun_d = startOfFrame && (pending_left != '0) && (snap != '0);

    // Clear wins over a coincident fruit acceptance.
    once_mask_d = clear_mask ? '0 : (once_mask_q | (acc_bit & ONCE_MASK));

    pending_cnt_d = '0;
    for (int i = 0; i < int'(NUM_SRC); i++) begin
      pending_cnt_d = pending_cnt_d + (ID_W+1)'(pending_q[i]);
    end

    // Scan downwards so the lowest set index is the one left standing.
    prio_id = '0;
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      if (pending_q[i]) prio_id = ID_W'(i);
    end
  end

  // Dispatch FSM next state and registered handshake outputs.
  always_comb begin
    state_d       = state_q;
    event_valid_d = event_valid_q;
    event_id_d    = event_id_q;
    unique case (state_q)
      StIdle: begin
        if (pending_q != '0) state_d = StLoad;
      end
      StLoad: begin
        event_id_d    = prio_id;
        event_valid_d = 1'b1;
        state_d       = StPresent;
      end
      StPresent: begin
        if (evt.event_ready) begin
          event_valid_d = 1'b0;
          state_d       = (pending_d != '0) ? StLoad : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= StIdle;
      accum_q       <= '0;
      pending_q     <= '0;
      once_mask_q   <= '0;
      event_valid_q <= 1'b0;
      event_id_q    <= '0;
      overrun_q     <= 1'b0;
      pending_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      accum_q       <= accum_d;
      pending_q     <= pending_d;
      once_mask_q   <= once_mask_d;
      event_valid_q <= event_valid_d;
      event_id_q    <= event_id_d;
      overrun_q     <= overrun_d;
      pending_cnt_q <= pending_cnt_d;
    end
  end

  assign evt.event_valid = event_valid_q;
  assign evt.event_id    = event_id_q;
  assign pending_cnt     = pending_cnt_q;
  assign overrun         = overrun_q;
  assign once_mask_o     = once_mask_q;

endmodule
